// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/done handshake, registered results held until the next completion.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r, q, dvs;
  logic [CW-1:0]    count;

  logic             accept;
  logic             zero_dvs;
  logic             last_iter;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r_nxt, q_nxt;

  assign accept    = start && (state == IDLE || state == DONE);
  assign zero_dvs  = (divisor == '0);
  assign last_iter = (count == CW'(1));

  // One restoring step. r < dvs always holds, so r_sh < 2*dvs and the
  // WIDTH+1-bit difference lies in (-dvs, dvs): its MSB is the borrow.
  always_comb begin
    r_sh  = {r, q[WIDTH-1]};
    diff  = r_sh - {1'b0, dvs};
    r_nxt = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    q_nxt = {q[WIDTH-2:0], ~diff[WIDTH]};
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; a start in DONE is treated exactly like one in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = zero_dvs ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      RUN:     if (last_iter) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Working registers and result registers; results load only on DONE entry
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (zero_dvs) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        q     <= dividend;
        r     <= '0;
        dvs   <= divisor;
        count <= CW'(WIDTH);
      end
    end else if (state == RUN) begin
      r     <= r_nxt;
      q     <= q_nxt;
      count <= count - CW'(1);
      if (last_iter) begin
        quotient    <= q_nxt;
        remainder   <= r_nxt;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider at WIDTH=4.
module tb_restoring_divider;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [3:0] dividend, divisor;
  logic [3:0] quotient, remainder;
  logic       busy, done, div_by_zero;

  int n_pass = 0;
  int n_total = 0;

  restoring_divider #(.WIDTH(4)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start for one edge, wait (bounded) for done, check results/latency.
  task automatic do_div(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                        input logic [3:0] eq, input logic [3:0] er, input logic ez,
                        input int elat);
    int cnt, nbusy;
    @(negedge clock); start = 1'b1; dividend = dd; divisor = dv;
    @(negedge clock); start = 1'b0;
    cnt = 1; nbusy = 0;
    while (!done && cnt < 40) begin
      if (busy) nbusy++;
      @(negedge clock); cnt++;
    end
    chk({tag, "_latency"}, cnt, elat);
    chk({tag, "_busy_cycles"}, nbusy, elat - 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
    @(negedge clock);
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int cnt, ndone;
    logic [3:0] a, b;
    start = 0; dividend = 0; divisor = 0; resetn = 0;
    repeat (2) @(negedge clock);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    resetn = 1;

    // 13/3: busy for 4 cycles, done the cycle after edge k+4
    do_div("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5);

    // 15/1 then 7/9 back-to-back, start held through the DONE cycle
    @(negedge clock); start = 1; dividend = 15; divisor = 1;
    @(negedge clock); start = 0;
    cnt = 1;
    while (!done && cnt < 40) begin
      if (cnt == 4) begin start = 1; dividend = 7; divisor = 9; end
      @(negedge clock); cnt++;
    end
    chk("b2b_first_latency", cnt, 5);
    chk("b2b_first_quotient", quotient, 15);
    chk("b2b_first_remainder", remainder, 0);
    @(negedge clock); start = 0;
    chk("b2b_no_gap_busy", busy, 1);
    chk("b2b_no_gap_done", done, 0);
    cnt = 1;
    while (!done && cnt < 40) begin @(negedge clock); cnt++; end
    chk("b2b_second_latency", cnt, 5);
    chk("b2b_second_quotient", quotient, 0);
    chk("b2b_second_remainder", remainder, 7);
    chk("b2b_second_dbz", div_by_zero, 0);

    // Divide by zero, then a normal divide clears the flag
    do_div("d9_0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1);
    do_div("d8_2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 5);

    // 14/4 with operands changed and start pulsed during RUN
    @(negedge clock); start = 1; dividend = 14; divisor = 4;
    @(negedge clock); start = 0;
    @(negedge clock); start = 1; dividend = 3; divisor = 1;
    @(negedge clock); start = 0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        chk("mid_run_quotient", quotient, 3);
        chk("mid_run_remainder", remainder, 2);
      end
      chk("busy_done_exclusive", busy & done, 0);
      @(negedge clock);
    end
    chk("mid_run_done_pulses", ndone, 1);

    // Asynchronous reset mid-RUN of 12/5
    @(negedge clock); start = 1; dividend = 12; divisor = 5;
    @(negedge clock); start = 0;
    @(negedge clock);
    #2 resetn = 0;
    #1;
    chk("async_rst_quotient", quotient, 0);
    chk("async_rst_remainder", remainder, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_dbz", div_by_zero, 0);
    @(negedge clock); resetn = 1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clock);
    end
    chk("async_rst_no_done", ndone, 0);
    do_div("d12_5", 4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 5);

    // Exhaustive sweep at WIDTH=4
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 4'(i); b = 4'(j);
        @(negedge clock); start = 1; dividend = a; divisor = b;
        @(negedge clock); start = 0;
        cnt = 1;
        while (!done && cnt < 40) begin @(negedge clock); cnt++; end
        chk("sweep_done_seen", done, 1);
        if (j == 0) begin
          chk("sweep_dbz_quotient", quotient, 15);
          chk("sweep_dbz_remainder", remainder, i);
          chk("sweep_dbz_flag", div_by_zero, 1);
        end else begin
          chk("sweep_invariant", quotient * j + remainder, i);
          chk("sweep_rem_lt_div", remainder < b, 1);
          chk("sweep_quotient", quotient, i / j);
          chk("sweep_dbz_clear", div_by_zero, 0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
